// File: rtl/change_dispenser.sv
// Greedy coin dispenser: breaks an 8-bit change amount into 10/5/2/1 coins
// through a request/acknowledge hopper handshake, with a sticky hopper-timeout fault.
//
// state  | meaning
// IDLE   | waiting for change_valid; coins_out holds last result
// SELECT | choose largest denomination <= remain
// EJECT  | coin_req high until hopper acks or timeout expires
// DONE   | one-cycle done pulse
// FAULT  | hopper timeout; left only by reset
module change_dispenser #(
  parameter int TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_change,
  input  logic       i_change_valid,
  input  logic       i_coin_ack,
  output logic       o_busy,
  output logic       o_coin_req,
  output logic [1:0] o_coin_sel,
  output logic [7:0] o_coins_out,
  output logic       o_done,
  output logic       o_fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_EJECT  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    r_state;
  logic [7:0]    r_remain;
  logic [7:0]    r_coins_out;
  logic [1:0]    r_coin_sel;
  logic [TW-1:0] r_tmo;

  logic [1:0]    w_sel;
  logic [7:0]    w_denom;

  always_comb begin
    if (r_remain >= 8'd10)     w_sel = 2'd0;
    else if (r_remain >= 8'd5) w_sel = 2'd1;
    else if (r_remain >= 8'd2) w_sel = 2'd2;
    else                       w_sel = 2'd3;
  end

  always_comb begin
    case (r_coin_sel)
      2'd0:    w_denom = 8'd10;
      2'd1:    w_denom = 8'd5;
      2'd2:    w_denom = 8'd2;
      default: w_denom = 8'd1;
    endcase
  end

  // Timeout is a down-counter: loaded with TIMEOUT-1 on the way into EJECT,
  // so terminal count zero coincides with the TIMEOUT-th unacknowledged cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remain    <= 8'd0;
      r_coins_out <= 8'd0;
      r_coin_sel  <= 2'd0;
      r_tmo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_change_valid) begin
            r_remain    <= i_change;
            r_coins_out <= 8'd0;
            r_state     <= (i_change != 8'd0) ? S_SELECT : S_DONE;
          end
        end
        S_SELECT: begin
          r_coin_sel <= w_sel;
          r_tmo      <= TW'(TIMEOUT - 1);
          r_state    <= S_EJECT;
        end
        S_EJECT: begin
          // An ack on the terminal-count cycle takes priority over the fault.
          if (i_coin_ack) begin
            r_remain    <= r_remain - w_denom;
            r_coins_out <= r_coins_out + 8'd1;
            r_state     <= (r_remain == w_denom) ? S_DONE : S_SELECT;
          end else if (r_tmo == '0) begin
            r_state <= S_FAULT;
          end else begin
            r_tmo <= r_tmo - TW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == S_SELECT) || (r_state == S_EJECT) || (r_state == S_DONE);
  assign o_coin_req  = (r_state == S_EJECT);
  assign o_coin_sel  = r_coin_sel;
  assign o_coins_out = r_coins_out;
  assign o_done      = (r_state == S_DONE);
  assign o_fault     = (r_state == S_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coin selections and coin counts
// are queued at stimulus time and checked as the hopper acks coins and done pulses.
module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic [7:0] change;
  logic       change_valid;
  logic       coin_ack;
  logic       busy;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic [7:0] coins_out;
  logic       done;
  logic       fault;

  int n_cmp;
  int n_err;
  int exp_sel[$];
  int exp_cnt[$];
  int ack_mode;
  int req_run;
  int req_cycles;
  int busy_nd;
  int done_cnt;
  int acks;

  change_dispenser #(.TIMEOUT(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_change       (change),
    .i_change_valid (change_valid),
    .i_coin_ack     (coin_ack),
    .o_busy         (busy),
    .o_coin_req     (coin_req),
    .o_coin_sel     (coin_sel),
    .o_coins_out    (coins_out),
    .o_done         (done),
    .o_fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Greedy reference: the sequence of coin indices and the total coin count.
  task automatic push_exp(input int v);
    int r;
    int n;
    r = v;
    n = 0;
    while (r > 0) begin
      if (r >= 10)     begin exp_sel.push_back(0); r -= 10; end
      else if (r >= 5) begin exp_sel.push_back(1); r -= 5;  end
      else if (r >= 2) begin exp_sel.push_back(2); r -= 2;  end
      else             begin exp_sel.push_back(3); r -= 1;  end
      n++;
    end
    exp_cnt.push_back(n);
  endtask

  // Hopper model: 0 never acks, 1 ack tied high, 2 toggles, 3 acks on the 16th request cycle.
  always @(posedge clk) begin
    #1;
    if (coin_req) req_run++;
    else          req_run = 0;
    case (ack_mode)
      0:       coin_ack = 1'b0;
      1:       coin_ack = 1'b1;
      2:       coin_ack = ~coin_ack;
      default: coin_ack = (req_run == 16);
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (coin_req) req_cycles++;
      if (busy && !done) busy_nd++;
      if (coin_req && coin_ack) begin
        acks++;
        if (exp_sel.size() == 0) chk("unexpected_coin", 1, 0);
        else chk("coin_sel", int'(coin_sel), exp_sel.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (exp_cnt.size() == 0) chk("unexpected_done", 1, 0);
        else chk("coins_out", int'(coins_out), exp_cnt.pop_front());
      end
    end
  end

  task automatic clear_stats();
    req_cycles = 0;
    busy_nd    = 0;
    done_cnt   = 0;
    acks       = 0;
  endtask

  task automatic drive(input int v, input bit push);
    @(posedge clk); #1;
    change       = 8'(v);
    change_valid = 1'b1;
    if (push) push_exp(v);
    @(posedge clk); #1;
    change_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #3;
      if (done_cnt != start) break;
    end
    chk(tag, done_cnt - start, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    exp_sel.delete();
    exp_cnt.delete();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    ack_mode = 1; req_run = 0;
    change = 8'd0; change_valid = 1'b0; coin_ack = 1'b0;
    clear_stats();
    rst = 1'b1;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_coin_req", int'(coin_req), 0);
    chk("rst_coin_sel", int'(coin_sel), 0);
    chk("rst_coins_out", int'(coins_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    @(posedge clk); #2 rst = 1'b0;

    // 45 with ack tied high: 4x10 + 1x5 at 2 cycles per coin
    ack_mode = 1; clear_stats();
    drive(45, 1'b1);
    wait_done("done_45", 60);
    chk("busy_cycles_45", busy_nd, 10);
    chk("acks_45", acks, 5);

    // 8 with toggling ack: 5,2,1
    ack_mode = 2; clear_stats();
    drive(8, 1'b1);
    wait_done("done_8", 60);
    chk("acks_8", acks, 3);

    // zero change: done the cycle right after capture, no request
    ack_mode = 1; clear_stats();
    drive(0, 1'b1);
    #2;
    chk("done_after_zero", int'(done), 1);
    @(posedge clk); #3;
    chk("req_zero", req_cycles, 0);
    chk("coins_hold_idle", int'(coins_out), 0);

    // maximum change: 26 coins
    clear_stats();
    drive(255, 1'b1);
    wait_done("done_255", 200);
    chk("acks_255", acks, 26);
    repeat (3) @(posedge clk);
    #3 chk("coins_hold_255", int'(coins_out), 26);

    // new request while busy is ignored
    clear_stats();
    drive(20, 1'b1);
    change = 8'd99; change_valid = 1'b1;
    @(posedge clk); #1 change_valid = 1'b0;
    wait_done("done_20", 60);
    repeat (4) @(posedge clk);
    #3 chk("done_count_20", done_cnt, 1);

    // ack lands on the very cycle the timeout expires: ack wins
    ack_mode = 3; clear_stats();
    drive(1, 1'b1);
    wait_done("done_ack_at_tmo", 60);
    chk("fault_ack_at_tmo", int'(fault), 0);
    chk("req_cycles_ack_at_tmo", req_cycles, 16);

    // hopper never acks: fault after 16 request cycles, sticky
    ack_mode = 0; clear_stats();
    drive(12, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #3;
      if (fault) break;
    end
    chk("fault_set", int'(fault), 1);
    chk("fault_req_cycles", req_cycles, 16);
    chk("fault_coin_req", int'(coin_req), 0);
    chk("fault_busy", int'(busy), 0);
    drive(5, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    chk("fault_sticky", int'(fault), 1);
    chk("fault_ignores_valid", int'(busy), 0);
    chk("fault_no_done", done_cnt, 0);
    do_reset();
    chk("fault_cleared", int'(fault), 0);

    // reset mid-transaction after the third coin
    ack_mode = 1; clear_stats();
    drive(255, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #3;
      if (acks >= 3) break;
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_coins_out", int'(coins_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_coin_req", int'(coin_req), 0);
    chk("midrst_coin_sel", int'(coin_sel), 0);
    do_reset();
    repeat (6) @(posedge clk);
    #3 chk("midrst_no_done", done_cnt, 0);

    // first strobe after reset release is captured on the next edge
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    clear_stats();
    change = 8'd3; change_valid = 1'b1;
    push_exp(3);
    @(posedge clk); #1 change_valid = 1'b0;
    #2 chk("post_rst_accept", int'(busy), 1);
    wait_done("done_post_rst", 30);

    chk("sel_queue_empty", exp_sel.size(), 0);
    chk("cnt_queue_empty", exp_cnt.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
